writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Writer-side front end for the 16-entry register file. Merges ALU results and out-of-order data-memory load responses into the file's single write port (a3/wd3/we3). Keeps a per-register pending-load scoreboard so that ALU writes never overtake an outstanding load to the same register. Buffers ALU results in a small FIFO. Sits between execute/memory and the register file.

Parameters:
DATA_W, 16, write-data width; matches the register file's wd3 port.
FIFO_DEPTH, 4, ALU result FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
alu_valid  in  1  ALU result offered
alu_rd  in  4  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted this cycle when high together with alu_valid
ld_issue_valid  in  1  load issued to memory
ld_issue_rd  in  4  load destination register
ld_issue_ready  out  1  issue accepted; low while busy[ld_issue_rd] is set
ld_rsp_valid  in  1  load data returning; always accepted
ld_rsp_rd  in  4  load destination register
ld_rsp_data  in  DATA_W  load data
a3  out  4  register-file write address
wd3  out  DATA_W  register-file write data
we3  out  1  register-file write enable
busy  out  16  scoreboard; bit n is set while a load to register n is outstanding
err  out  2  sticky error flags; bit0 = write to r15 attempted, bit1 = orphan load response

Behaviour:
- Reset (asynchronous, any cycle, including mid-drain):
  - we3=0, a3=0, wd3=0, busy=0, err=0.
  - FIFO emptied; pointers cleared; in-flight data is discarded.
- alu_ready = !fifo_full (combinational).
  - Push when alu_valid && alu_ready.
  - A pop in the same cycle does not make room while the FIFO is full.
- Write select, evaluated each cycle. Priority order:
  1. ld_rsp_valid: write ld_rsp_rd/ld_rsp_data; clear busy[ld_rsp_rd].
  2. Else, if the FIFO is non-empty and busy[head.rd]=0: pop the head and write it.
  3. Else, no write.
- Head-of-line stall: if busy[head.rd]=1, the FIFO does not pop. Younger entries wait behind it, so program order is preserved.
- Write-port timing: outputs are registered. The selected write appears as we3=1 with a3/wd3 on the cycle after selection. we3 is high for exactly 1 cycle per write.
  - Latency, empty FIFO to register file: ALU accept (cycle N) -> we3 at N+2, because the push and the pop happen in separate cycles.
  - Latency, load response: N -> N+1.
- Scoreboard:
  - ld_issue_valid && ld_issue_ready sets busy[ld_issue_rd].
  - Issue and response to the same rd in the same cycle: the issue is blocked because busy is set, so no conflict arises.
  - Issue to register A while a response arrives for register B: both take effect.
- r15 (program counter, sourced externally):
  - ALU entry with rd=15: popped normally, we3 stays 0, err[0] set.
  - Load issue with rd=15: accepted, busy[15] never set, err[0] set.
  - Load response with rd=15: dropped, err[0] set.
- Orphan response (ld_rsp_valid with busy[rd]=0, rd≠15): the write is still performed and err[1] is set.
- err bits clear only on rst.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

Optional Feature:
Macro: WB_FORWARD_EN.
- When defined, adds three ports:
  - fwd_addr (in, 4): register address to look up.
  - fwd_hit (out, 1): combinational hit flag.
  - fwd_data (out, DATA_W): combinational forwarded data.
- fwd_hit=1 when busy[fwd_addr]=0, fwd_addr≠15, and a match exists in either:
  - a valid FIFO entry (the youngest match wins), or
  - the registered write stage (we3 && a3==fwd_addr).
- FIFO matches take priority over the write stage. fwd_data carries the matched value.
- On a miss, fwd_hit=0 and fwd_data=0.
- When the macro is undefined, the ports and lookup logic are absent. All other behaviour is identical.

Test Plan:
- Reset then a single ALU write (rd=3, data=16'h00A5) at cycle 0 -> we3=1, a3=3, wd3=16'h00A5 at cycle 2 only; busy=0; err=0.
- Load issue rd=5, then ALU rd=5 data=16'h1111, then load response rd=5 data=16'h2222 five cycles later -> the load write (16'h2222) precedes the ALU write (16'h1111); the final write to r5 is 16'h1111; busy[5] clears on the response cycle.
- Fill the FIFO with 4 ALU writes while load 2 is pending (all rd=2) -> alu_ready=0 on the 5th offer; no we3 until the response; then 5 consecutive we3 pulses in order.
- ALU write with rd=15 (data=16'hBEEF) -> we3 never asserted for it; err=2'b01; a subsequent rd=4 write proceeds normally.
- ld_rsp_valid with rd=7, data=16'h0042, busy[7]=0 -> we3 with a3=7, wd3=16'h0042; err[1]=1.
- Assert rst mid-stream with 3 FIFO entries and busy[1] set -> we3, busy, err and FIFO count read 0 immediately, without waiting for a clock edge; with WB_FORWARD_EN defined, fwd_hit=0 for all addresses.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results (via a small in-order FIFO) and
// out-of-order load responses onto the register file's single write port.
// A per-register pending-load scoreboard keeps ALU writes from overtaking
// an outstanding load to the same register. r15 is never written.
// Optional macro WB_FORWARD_EN adds a combinational forwarding lookup
// (fwd_addr / fwd_hit / fwd_data).
module writeback_unit #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [3:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_issue_valid,
    input  logic [3:0]        ld_issue_rd,
    output logic              ld_issue_ready,
    input  logic              ld_rsp_valid,
    input  logic [3:0]        ld_rsp_rd,
    input  logic [DATA_W-1:0] ld_rsp_data,
    output logic [3:0]        a3,
    output logic [DATA_W-1:0] wd3,
    output logic              we3,
    output logic [15:0]       busy,
    output logic [1:0]        err
`ifdef WB_FORWARD_EN
    ,
    input  logic [3:0]        fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;   // extra bit separates full from empty

    typedef struct packed {
        logic [3:0]        rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t [FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]           busy_q, busy_d;
    logic [1:0]            err_q, err_d;
    logic                  we3_q, we3_d;
    logic [3:0]            a3_q, a3_d;
    logic [DATA_W-1:0]     wd3_q, wd3_d;

    logic fifo_empty, fifo_full, push, pop;
    ent_t head;

    assign fifo_empty     = (wptr_q == rptr_q);
    assign fifo_full      = (wptr_q[AW] != rptr_q[AW]) &&
                            (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head           = mem_q[rptr_q[AW-1:0]];
    assign alu_ready      = !fifo_full;
    assign push           = alu_valid && !fifo_full;
    // Head pops only when no load response claims the port and its
    // destination has no outstanding load (head-of-line stall otherwise).
    assign pop            = !ld_rsp_valid && !fifo_empty && !busy_q[head.rd];
    assign ld_issue_ready = !busy_q[ld_issue_rd];

    assign a3   = a3_q;
    assign wd3  = wd3_q;
    assign we3  = we3_q;
    assign busy = busy_q;
    assign err  = err_q;

    // Next-state: write select, scoreboard update, error flags, FIFO push/pop.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        busy_d = busy_q;
        err_d  = err_q;
        we3_d  = 1'b0;
        a3_d   = a3_q;
        wd3_d  = wd3_q;

        if (ld_rsp_valid) begin
            if (ld_rsp_rd == 4'd15) begin
                err_d[0] = 1'b1;
            end else begin
                we3_d = 1'b1;
                a3_d  = ld_rsp_rd;
                wd3_d = ld_rsp_data;
                if (!busy_q[ld_rsp_rd]) err_d[1] = 1'b1;
                busy_d[ld_rsp_rd] = 1'b0;
            end
        end else if (pop) begin
            rptr_d = rptr_q + PW'(1);
            if (head.rd == 4'd15) begin
                err_d[0] = 1'b1;
            end else begin
                we3_d = 1'b1;
                a3_d  = head.rd;
                wd3_d = head.data;
            end
        end

        // Issue is applied after the response clear so a newer issue wins.
        if (ld_issue_valid && ld_issue_ready) begin
            if (ld_issue_rd == 4'd15) err_d[0] = 1'b1;
            else                      busy_d[ld_issue_rd] = 1'b1;
        end

        if (push) begin
            mem_d[wptr_q[AW-1:0]] = '{rd: alu_rd, data: alu_data};
            wptr_d = wptr_q + PW'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            busy_q <= '0;
            err_q  <= '0;
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
        end
    end

`ifdef WB_FORWARD_EN
    logic [PW-1:0] fwd_cnt;
    logic [AW-1:0] fwd_idx;

    // Forward lookup: write stage first, then FIFO oldest->youngest so the
    // youngest FIFO match overrides everything before it.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_cnt  = wptr_q - rptr_q;
        fwd_idx  = '0;
        if (fwd_addr != 4'd15 && !busy_q[fwd_addr]) begin
            if (we3_q && a3_q == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = wd3_q;
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fwd_idx = rptr_q[AW-1:0] + AW'(k);
                if (PW'(k) < fwd_cnt && mem_q[fwd_idx].rd == fwd_addr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem_q[fwd_idx].data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: table of directed per-cycle vectors, hand
// sequences for FIFO-full and asynchronous reset, then random traffic
// checked against a queue-based reference model.
module tb_writeback_unit;

    logic        clk, rst;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        ld_issue_valid, ld_issue_ready;
    logic [3:0]  ld_issue_rd;
    logic        ld_rsp_valid;
    logic [3:0]  ld_rsp_rd;
    logic [15:0] ld_rsp_data;
    logic [3:0]  a3;
    logic [15:0] wd3;
    logic        we3;
    logic [15:0] busy;
    logic [1:0]  err;
`ifdef WB_FORWARD_EN
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    writeback_unit #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_rd(ld_rsp_rd), .ld_rsp_data(ld_rsp_data),
        .a3(a3), .wd3(wd3), .we3(we3), .busy(busy), .err(err)
`ifdef WB_FORWARD_EN
        , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ALU FIFO as a queue, scoreboard as a bit vector.
    typedef struct { logic [3:0] rd; logic [15:0] data; } ment_t;
    ment_t       mq[$];
    logic [15:0] mbusy;
    logic [1:0]  merr;
    logic        mwe;
    logic [3:0]  ma3;
    logic [15:0] mwd;

    task automatic model_clear();
        mq.delete();
        mbusy = '0;
        merr  = '0;
        mwe   = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check ready outputs, advance model,
    // then check registered outputs at the following negedge.
    task automatic step(input logic av, input logic [3:0] ard, input logic [15:0] ad,
                        input logic iv, input logic [3:0] ird,
                        input logic rv, input logic [3:0] rrd, input logic [15:0] rdat);
        logic  rdy, irdy;
        ment_t e;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_issue_valid = iv; ld_issue_rd = ird;
        ld_rsp_valid = rv; ld_rsp_rd = rrd; ld_rsp_data = rdat;
        #1;
        rdy  = (mq.size() < 4);
        irdy = (ird == 4'd15) || !mbusy[ird];
        chk("alu_ready", {31'b0, alu_ready}, {31'b0, rdy});
        chk("ld_issue_ready", {31'b0, ld_issue_ready}, {31'b0, irdy});
        mwe = 1'b0;
        if (rv) begin
            if (rrd == 4'd15) merr[0] = 1'b1;
            else begin
                mwe = 1'b1; ma3 = rrd; mwd = rdat;
                if (!mbusy[rrd]) merr[1] = 1'b1;
                mbusy[rrd] = 1'b0;
            end
        end else if (mq.size() > 0 && !mbusy[mq[0].rd]) begin
            e = mq.pop_front();
            if (e.rd == 4'd15) merr[0] = 1'b1;
            else begin
                mwe = 1'b1; ma3 = e.rd; mwd = e.data;
            end
        end
        if (iv && irdy) begin
            if (ird == 4'd15) merr[0] = 1'b1;
            else              mbusy[ird] = 1'b1;
        end
        if (av && rdy) mq.push_back('{ard, ad});
        @(posedge clk);
        @(negedge clk);
        chk("we3", {31'b0, we3}, {31'b0, mwe});
        if (mwe) begin
            chk("a3", {28'b0, a3}, {28'b0, ma3});
            chk("wd3", {16'b0, wd3}, {16'b0, mwd});
        end
        chk("busy", {16'b0, busy}, {16'b0, mbusy});
        chk("err", {30'b0, err}, {30'b0, merr});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic av; logic [3:0] ard; logic [15:0] ad;
        logic iv; logic [3:0] ird;
        logic rv; logic [3:0] rrd; logic [15:0] rdat;
        logic ewe; logic [3:0] ea3; logic [15:0] ewd; logic [15:0] ebusy; logic [1:0] eerr;
    } vec_t;
    vec_t tbl[21];

    initial begin
        // Hand-derived per-cycle vectors; expected values are post-edge outputs.
        tbl[0]  = '{1,  3, 16'h00A5, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 2'b00};
        tbl[1]  = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 1,  3, 16'h00A5, 16'h0000, 2'b00};
        tbl[2]  = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 2'b00};
        tbl[3]  = '{0,  0, 16'h0000, 1,  5, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0020, 2'b00};
        tbl[4]  = '{1,  5, 16'h1111, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0020, 2'b00};
        tbl[5]  = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0020, 2'b00};
        tbl[6]  = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0020, 2'b00};
        tbl[7]  = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0020, 2'b00};
        tbl[8]  = '{0,  0, 16'h0000, 0,  0, 1,  5, 16'h2222, 1,  5, 16'h2222, 16'h0000, 2'b00};
        tbl[9]  = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 1,  5, 16'h1111, 16'h0000, 2'b00};
        tbl[10] = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 2'b00};
        tbl[11] = '{1, 15, 16'hBEEF, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 2'b00};
        tbl[12] = '{1,  4, 16'h0404, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 2'b01};
        tbl[13] = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 1,  4, 16'h0404, 16'h0000, 2'b01};
        tbl[14] = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 2'b01};
        tbl[15] = '{0,  0, 16'h0000, 0,  0, 1,  7, 16'h0042, 1,  7, 16'h0042, 16'h0000, 2'b11};
        tbl[16] = '{0,  0, 16'h0000, 0,  0, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 2'b11};
        tbl[17] = '{0,  0, 16'h0000, 1,  9, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0200, 2'b11};
        tbl[18] = '{0,  0, 16'h0000, 1, 10, 1,  9, 16'h9999, 1,  9, 16'h9999, 16'h0400, 2'b11};
        tbl[19] = '{0,  0, 16'h0000, 0,  0, 1, 10, 16'h0AAA, 1, 10, 16'h0AAA, 16'h0000, 2'b11};
        tbl[20] = '{0,  0, 16'h0000, 1, 15, 0,  0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 2'b11};

        clk = 0; rst = 1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue_valid = 0; ld_issue_rd = 0;
        ld_rsp_valid = 0; ld_rsp_rd = 0; ld_rsp_data = 0;
`ifdef WB_FORWARD_EN
        fwd_addr = 0;
`endif
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_we3", {31'b0, we3}, 0);
        chk("rst_a3", {28'b0, a3}, 0);
        chk("rst_wd3", {16'b0, wd3}, 0);
        chk("rst_busy", {16'b0, busy}, 0);
        chk("rst_err", {30'b0, err}, 0);
        rst = 0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].iv, tbl[i].ird,
                 tbl[i].rv, tbl[i].rrd, tbl[i].rdat);
            chk($sformatf("tbl%0d_we3", i), {31'b0, we3}, {31'b0, tbl[i].ewe});
            if (tbl[i].ewe) begin
                chk($sformatf("tbl%0d_a3", i), {28'b0, a3}, {28'b0, tbl[i].ea3});
                chk($sformatf("tbl%0d_wd3", i), {16'b0, wd3}, {16'b0, tbl[i].ewd});
            end
            chk($sformatf("tbl%0d_busy", i), {16'b0, busy}, {16'b0, tbl[i].ebusy});
            chk($sformatf("tbl%0d_err", i), {30'b0, err}, {30'b0, tbl[i].eerr});
        end

        // FIFO full behind a pending load to r2.
        step(0, 0, 0, 1, 2, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(1, 2, 16'(k), 0, 0, 0, 0, 0);
            chk("full_fill_we3", {31'b0, we3}, 0);
        end
        alu_valid = 1; alu_rd = 2; alu_data = 16'h0005;
        #1;
        chk("full_ready", {31'b0, alu_ready}, 0);
        step(1, 2, 16'h0005, 0, 0, 0, 0, 0);
        chk("full_stall_we3", {31'b0, we3}, 0);
        step(0, 0, 0, 0, 0, 1, 2, 16'hD00D);
        chk("full_rsp_we3", {31'b0, we3}, 1);
        chk("full_rsp_wd3", {16'b0, wd3}, 16'hD00D);
        for (int k = 1; k <= 4; k++) begin
            idle();
            chk("full_drain_we3", {31'b0, we3}, 1);
            chk("full_drain_a3", {28'b0, a3}, 2);
            chk("full_drain_wd3", {16'b0, wd3}, k);
        end
        idle();
        chk("full_done_we3", {31'b0, we3}, 0);

        // Asynchronous reset mid-stream: 3 entries stuck behind busy[1].
        step(0, 0, 0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 16'h0010 + 16'(k), 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 8, 16'h0808);
        chk("pre_rst_we3", {31'b0, we3}, 1);
        rst = 1;
        #1;
        chk("async_rst_we3", {31'b0, we3}, 0);
        chk("async_rst_busy", {16'b0, busy}, 0);
        chk("async_rst_err", {30'b0, err}, 0);
        chk("async_rst_ready", {31'b0, alu_ready}, 1);
`ifdef WB_FORWARD_EN
        for (int a = 0; a < 16; a++) begin
            fwd_addr = 4'(a);
            #1;
            chk("async_rst_fwd_hit", {31'b0, fwd_hit}, 0);
        end
`endif
        @(negedge clk);
        rst = 0;
        model_clear();
        repeat (3) idle();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic       av, iv, rv;
            logic [3:0] ard, ird, rrd;
            int         st;
            av  = ($urandom_range(0, 1) == 1);
            ard = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            iv  = ($urandom_range(0, 3) == 0);
            ird = ($urandom_range(0, 20) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            rv  = ($urandom_range(0, 3) == 0);
            rrd = 4'($urandom_range(0, 15));
            if (mbusy != 0 && $urandom_range(0, 7) != 0) begin
                st = $urandom_range(0, 15);
                for (int j = 0; j < 16; j++)
                    if (mbusy[4'(st + j)]) rrd = 4'(st + j);
            end
            step(av, ard, 16'($urandom), iv, ird, rv, rrd, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
